// File: rtl/a_axi_write_response_gather_4_to_1_pkg.sv
// Shared definitions for the 4-to-1 AXI-Lite B-channel gather: SLR count,
// response encodings and the severity-max helper used by the join.
package a_axi_write_response_gather_4_to_1_pkg;

  localparam int NUM_SLR = 4;
  localparam int RESP_W  = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } bresp_e;

  // Encodings are ordered by severity, so the worst response is the numeric max.
  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/a_axi_write_response_gather_4_to_1_b_resp_fifo.sv
// Small per-SLR response FIFO with registered full_n/empty_n and an occupancy
// count; full_n doubles as the registered BREADY back to the SLR.
module b_resp_fifo
  import a_axi_write_response_gather_4_to_1_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [RESP_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [RESP_W-1:0] rdata_o,
  output logic              full_n_o,
  output logic              empty_n_o,
  output logic [ADDR_W:0]   occ_o
);

  localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [RESP_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              full_n_q, empty_n_q;
  logic              push, pop;

  assign push = push_i & full_n_q;
  assign pop  = pop_i & empty_n_q;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_ONE;
    else if (pop && !push) occ_d = occ_q - OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      full_n_q  <= 1'b0;
      empty_n_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      occ_q     <= occ_d;
      full_n_q  <= (occ_d != OCC_FULL);
      empty_n_q <= (occ_d != '0);
    end
  end

  assign rdata_o   = mem_q[rptr_q];
  assign full_n_o  = full_n_q;
  assign empty_n_o = empty_n_q;
  assign occ_o     = occ_q;

endmodule

// File: rtl/a_axi_write_response_gather_4_to_1.sv
// Joins the four per-SLR B responses of a broadcast write into one host B
// response (worst code wins), tracking outstanding writes and protocol errors.
module a_axi_write_response_gather_4_to_1
  import a_axi_write_response_gather_4_to_1_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_ADDR_WIDTH = 2,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 s_axi_control_BVALID_slr_0,
  output logic                 s_axi_control_BREADY_slr_0,
  input  logic [RESP_W-1:0]    s_axi_control_BRESP_slr_0,
  input  logic                 s_axi_control_BVALID_slr_1,
  output logic                 s_axi_control_BREADY_slr_1,
  input  logic [RESP_W-1:0]    s_axi_control_BRESP_slr_1,
  input  logic                 s_axi_control_BVALID_slr_2,
  output logic                 s_axi_control_BREADY_slr_2,
  input  logic [RESP_W-1:0]    s_axi_control_BRESP_slr_2,
  input  logic                 s_axi_control_BVALID_slr_3,
  output logic                 s_axi_control_BREADY_slr_3,
  input  logic [RESP_W-1:0]    s_axi_control_BRESP_slr_3,
  output logic                 s_axi_control_BVALID,
  input  logic                 s_axi_control_BREADY,
  output logic [RESP_W-1:0]    s_axi_control_BRESP,
  input  logic                 aw_fire,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 err_spurious,
  output logic                 err_overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam int CMP_W = ((CNT_WIDTH > FIFO_ADDR_WIDTH + 1) ? CNT_WIDTH : FIFO_ADDR_WIDTH + 1) + 1;

  logic [NUM_SLR-1:0]                    slr_vld, slr_rdy, push, empty_n;
  logic [NUM_SLR-1:0][RESP_W-1:0]        slr_resp, rdata;
  logic [NUM_SLR-1:0][FIFO_ADDR_WIDTH:0] occ;

  logic                 bvalid_q, bvalid_d;
  logic [RESP_W-1:0]    bresp_q, bresp_d, resp_worst;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 spur_q, spur_d, ovf_q, ovf_d;
  logic                 join_pop, host_hs, spur_hit;
  logic [CMP_W-1:0]     expect_cnt;

  assign slr_vld  = {s_axi_control_BVALID_slr_3, s_axi_control_BVALID_slr_2,
                     s_axi_control_BVALID_slr_1, s_axi_control_BVALID_slr_0};
  assign slr_resp = {s_axi_control_BRESP_slr_3, s_axi_control_BRESP_slr_2,
                     s_axi_control_BRESP_slr_1, s_axi_control_BRESP_slr_0};
  assign s_axi_control_BREADY_slr_0 = slr_rdy[0];
  assign s_axi_control_BREADY_slr_1 = slr_rdy[1];
  assign s_axi_control_BREADY_slr_2 = slr_rdy[2];
  assign s_axi_control_BREADY_slr_3 = slr_rdy[3];

  assign push     = slr_vld & slr_rdy;
  assign host_hs  = bvalid_q & s_axi_control_BREADY;
  // All four FIFOs pop together or not at all, keeping the SLR streams aligned.
  assign join_pop = (&empty_n) & (~bvalid_q | s_axi_control_BREADY);

  for (genvar g = 0; g < NUM_SLR; g++) begin : g_slr
    b_resp_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (FIFO_ADDR_WIDTH)
    ) u_fifo (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .push_i    (push[g]),
      .wdata_i   (slr_resp[g]),
      .pop_i     (join_pop),
      .rdata_o   (rdata[g]),
      .full_n_o  (slr_rdy[g]),
      .empty_n_o (empty_n[g]),
      .occ_o     (occ[g])
    );
  end

  always_comb begin
    resp_worst = rdata[0];
    for (int k = 1; k < NUM_SLR; k++) resp_worst = resp_max(resp_worst, rdata[k]);
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (join_pop) begin
      bvalid_d = 1'b1;
      bresp_d  = resp_worst;
    end else if (s_axi_control_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (aw_fire && !host_hs) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end else if (host_hs && !aw_fire && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // An SLR already holding as many undelivered responses as there are writes
  // in flight (including this cycle's AW) is answering a write that never existed.
  always_comb begin
    spur_hit   = 1'b0;
    expect_cnt = CMP_W'(cnt_q) + CMP_W'(aw_fire);
    for (int k = 0; k < NUM_SLR; k++) begin
      if (push[k] && (CMP_W'(occ[k]) + CMP_W'(bvalid_q) >= expect_cnt)) spur_hit = 1'b1;
    end
    spur_d = spur_q | spur_hit;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      cnt_q    <= '0;
      spur_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      cnt_q    <= cnt_d;
      spur_q   <= spur_d;
      ovf_q    <= ovf_d;
    end
  end

  assign s_axi_control_BVALID = bvalid_q;
  assign s_axi_control_BRESP  = bresp_q;
  assign outstanding          = cnt_q;
  assign err_spurious         = spur_q;
  assign err_overflow         = ovf_q;

endmodule
